// File: rtl/gf180mcu_osu_sc_9t_tbuf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_osu_sc_9t_tbuf_arb_pkg
// Brief    : Shared types and widths for the 4-way tristate-bus arbiter.
// Revision : 1.0
// ============================================================================
package gf180mcu_osu_sc_9t_tbuf_arb_pkg;

  localparam int NREQ       = 4;
  localparam int OWNER_W    = 2;
  localparam int DEAD_CNT_W = 4;
  localparam int HOLD_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DEAD  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/gf180mcu_osu_sc_9t_tbuf_arb4_if.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_osu_sc_9t_tbuf_arb4_if
// Brief    : Request/grant/enable bundle between requesters and the arbiter.
// Revision : 1.0
// ============================================================================
interface gf180mcu_osu_sc_9t_tbuf_arb4_if;
  import gf180mcu_osu_sc_9t_tbuf_arb_pkg::*;

  logic [NREQ-1:0]    REQ;
  logic [NREQ-1:0]    GNT;
  logic [NREQ-1:0]    EN;
  logic [NREQ-1:0]    EN_BAR;
  logic [OWNER_W-1:0] OWNER;
  logic               BUSY;

  modport master (output REQ, input GNT, input EN, input EN_BAR, input OWNER, input BUSY);
  modport slave  (input REQ, output GNT, output EN, output EN_BAR, output OWNER, output BUSY);

endinterface
`default_nettype wire

// File: rtl/gf180mcu_osu_sc_9t_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_osu_sc_9t_rr_pick
// Brief    : Combinational round-robin picker; first requester at or after ptr.
// Revision : 1.0
// ============================================================================
module gf180mcu_osu_sc_9t_rr_pick
  import gf180mcu_osu_sc_9t_tbuf_arb_pkg::*;
(
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] ptr,
  output logic               any,
  output logic [OWNER_W-1:0] idx
);

  logic [OWNER_W-1:0] cand;
  logic               found;

  always_comb begin
    any   = |req;
    idx   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      // Index arithmetic wraps naturally in OWNER_W bits
      cand = ptr + OWNER_W'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gf180mcu_osu_sc_9t_tbuf_arb4.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_osu_sc_9t_tbuf_arb4
// Brief    : 4-way round-robin tristate-bus arbiter with dead time between
//            owners; optional hold limit under GF180MCU_OSU_SC_TBUF_ARB_HOLD_LIMIT_EN.
// Revision : 1.0
// ============================================================================
module gf180mcu_osu_sc_9t_tbuf_arb4
  import gf180mcu_osu_sc_9t_tbuf_arb_pkg::*;
#(
  parameter int DEAD_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic CLK,
  input  logic RN,
  gf180mcu_osu_sc_9t_tbuf_arb4_if.slave bus
);

  localparam logic [DEAD_CNT_W-1:0] DEAD_INIT = DEAD_CNT_W'(DEAD_CYC - 1);

  if ((DEAD_CYC < 1) || (DEAD_CYC > 15)) begin : g_bad_dead_cyc
    $error("DEAD_CYC must be in 1..15");
  end
  if ((MAX_HOLD < 1) || (MAX_HOLD > 255)) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 1..255");
  end

  state_e                state_q;
  logic [NREQ-1:0]       en_q;
  logic [OWNER_W-1:0]    owner_q;
  logic [OWNER_W-1:0]    ptr_q;
  logic [DEAD_CNT_W-1:0] dead_cnt_q;
  logic                  busy_q;

  logic                  pick_any;
  logic [OWNER_W-1:0]    pick_idx;
  logic [NREQ-1:0]       en_d;
  logic                  hold_expired;

  gf180mcu_osu_sc_9t_rr_pick u_pick (
    .req (bus.REQ),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign en_d = NREQ'(1) << pick_idx;

`ifdef GF180MCU_OSU_SC_TBUF_ARB_HOLD_LIMIT_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD);
  logic [HOLD_CNT_W-1:0] hold_cnt_q;
  assign hold_expired = (hold_cnt_q == HOLD_LAST);
`else
  assign hold_expired = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q    <= ST_IDLE;
      en_q       <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      dead_cnt_q <= '0;
      busy_q     <= 1'b0;
`ifdef GF180MCU_OSU_SC_TBUF_ARB_HOLD_LIMIT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            state_q <= ST_DRIVE;
            en_q    <= en_d;
            owner_q <= pick_idx;
            busy_q  <= 1'b1;
`ifdef GF180MCU_OSU_SC_TBUF_ARB_HOLD_LIMIT_EN
            hold_cnt_q <= HOLD_CNT_W'(1);
`endif
          end
        end

        ST_DRIVE: begin
          // Owner release (or hold-limit preemption) opens the dead gap and
          // demotes the old owner to lowest priority.
          if (!bus.REQ[owner_q] || hold_expired) begin
            state_q    <= ST_DEAD;
            en_q       <= '0;
            ptr_q      <= owner_q + OWNER_W'(1);
            dead_cnt_q <= DEAD_INIT;
          end
`ifdef GF180MCU_OSU_SC_TBUF_ARB_HOLD_LIMIT_EN
          else begin
            hold_cnt_q <= hold_cnt_q + HOLD_CNT_W'(1);
          end
`endif
        end

        ST_DEAD: begin
          if (dead_cnt_q != '0) begin
            dead_cnt_q <= dead_cnt_q - DEAD_CNT_W'(1);
          end else if (pick_any) begin
            state_q <= ST_DRIVE;
            en_q    <= en_d;
            owner_q <= pick_idx;
            busy_q  <= 1'b1;
`ifdef GF180MCU_OSU_SC_TBUF_ARB_HOLD_LIMIT_EN
            hold_cnt_q <= HOLD_CNT_W'(1);
`endif
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          en_q    <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.EN     = en_q;
  assign bus.GNT    = en_q;
  assign bus.EN_BAR = ~en_q;
  assign bus.OWNER  = owner_q;
  assign bus.BUSY   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_osu_sc_9t_tbuf_arb4.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf180mcu_osu_sc_9t_tbuf_arb4
// Brief    : Directed and random self-checking bench for the 4-way tbuf arbiter.
// Revision : 1.0
// ============================================================================
module tb_gf180mcu_osu_sc_9t_tbuf_arb4;

  localparam int A_DEAD = 1;

  logic CLK;
  logic RN;
  int   n_checks;
  int   n_fail;

  gf180mcu_osu_sc_9t_tbuf_arb4_if bus_a ();
  gf180mcu_osu_sc_9t_tbuf_arb4_if bus_b ();
  gf180mcu_osu_sc_9t_tbuf_arb4_if bus_h ();

  gf180mcu_osu_sc_9t_tbuf_arb4 #(.DEAD_CYC(A_DEAD), .MAX_HOLD(16)) u_dut_a (
    .CLK (CLK), .RN (RN), .bus (bus_a.slave));
  gf180mcu_osu_sc_9t_tbuf_arb4 #(.DEAD_CYC(3), .MAX_HOLD(16)) u_dut_b (
    .CLK (CLK), .RN (RN), .bus (bus_b.slave));
  gf180mcu_osu_sc_9t_tbuf_arb4 #(.DEAD_CYC(1), .MAX_HOLD(4)) u_dut_h (
    .CLK (CLK), .RN (RN), .bus (bus_h.slave));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RN = 1'b0;
    bus_a.REQ = '0; bus_b.REQ = '0; bus_h.REQ = '0;
    tick(); tick();
    n_checks++;
    if ({bus_a.GNT, bus_a.EN, bus_a.EN_BAR, bus_a.OWNER, bus_a.BUSY} !== 15'b0000_0000_1111_00_0) begin
      n_fail++;
      $display("FAIL reset_a: gnt=%b en=%b en_bar=%b owner=%0d busy=%b, expected 0000 0000 1111 0 0",
               bus_a.GNT, bus_a.EN, bus_a.EN_BAR, bus_a.OWNER, bus_a.BUSY);
    end
    n_checks++;
    if ({bus_b.GNT, bus_b.EN, bus_b.EN_BAR, bus_b.OWNER, bus_b.BUSY} !== 15'b0000_0000_1111_00_0) begin
      n_fail++;
      $display("FAIL reset_b: gnt=%b en=%b en_bar=%b owner=%0d busy=%b, expected 0000 0000 1111 0 0",
               bus_b.GNT, bus_b.EN, bus_b.EN_BAR, bus_b.OWNER, bus_b.BUSY);
    end
    n_checks++;
    if ({bus_h.GNT, bus_h.EN, bus_h.EN_BAR, bus_h.OWNER, bus_h.BUSY} !== 15'b0000_0000_1111_00_0) begin
      n_fail++;
      $display("FAIL reset_h: gnt=%b en=%b en_bar=%b owner=%0d busy=%b, expected 0000 0000 1111 0 0",
               bus_h.GNT, bus_h.EN, bus_h.EN_BAR, bus_h.OWNER, bus_h.BUSY);
    end
  endtask

  // Table entries: {rn, req[3:0], gnt[3:0], owner[1:0], busy}
  task automatic test_rr_basic();
    logic [11:0] tv [6];
    logic [3:0]  g;
    tv = '{ {1'b1, 4'b0110, 4'b0010, 2'd1, 1'b1},
            {1'b1, 4'b0110, 4'b0010, 2'd1, 1'b1},
            {1'b1, 4'b0100, 4'b0000, 2'd0, 1'b1},
            {1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1},
            {1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1},
            {1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0} };
    for (int s = 0; s < 6; s++) begin
      RN = tv[s][11]; bus_a.REQ = tv[s][10:7];
      tick();
      g = tv[s][6:3];
      n_checks++;
      if ({bus_a.GNT, bus_a.EN, bus_a.EN_BAR, bus_a.BUSY} !== {g, g, ~g, tv[s][0]}) begin
        n_fail++;
        $display("FAIL rr_basic step %0d: gnt=%b en=%b en_bar=%b busy=%b, expected gnt=en=%b busy=%b",
                 s, bus_a.GNT, bus_a.EN, bus_a.EN_BAR, bus_a.BUSY, g, tv[s][0]);
      end
      if (g != 4'b0000) begin
        n_checks++;
        if (bus_a.OWNER !== tv[s][2:1]) begin
          n_fail++;
          $display("FAIL rr_basic owner step %0d: owner=%0d expected %0d", s, bus_a.OWNER, tv[s][2:1]);
        end
      end
    end
  endtask

  task automatic test_rotation();
    logic [11:0] tv [7];
    logic [3:0]  g;
    tv = '{ {1'b1, 4'b1111, 4'b1000, 2'd3, 1'b1},
            {1'b1, 4'b0111, 4'b0000, 2'd0, 1'b1},
            {1'b1, 4'b0111, 4'b0001, 2'd0, 1'b1},
            {1'b1, 4'b0110, 4'b0000, 2'd0, 1'b1},
            {1'b1, 4'b0110, 4'b0010, 2'd1, 1'b1},
            {1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1},
            {1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0} };
    for (int s = 0; s < 7; s++) begin
      RN = tv[s][11]; bus_a.REQ = tv[s][10:7];
      tick();
      g = tv[s][6:3];
      n_checks++;
      if ({bus_a.GNT, bus_a.EN, bus_a.EN_BAR, bus_a.BUSY} !== {g, g, ~g, tv[s][0]}) begin
        n_fail++;
        $display("FAIL rotation step %0d: gnt=%b en=%b en_bar=%b busy=%b, expected gnt=en=%b busy=%b",
                 s, bus_a.GNT, bus_a.EN, bus_a.EN_BAR, bus_a.BUSY, g, tv[s][0]);
      end
      if (g != 4'b0000) begin
        n_checks++;
        if (bus_a.OWNER !== tv[s][2:1]) begin
          n_fail++;
          $display("FAIL rotation owner step %0d: owner=%0d expected %0d", s, bus_a.OWNER, tv[s][2:1]);
        end
      end
    end
  endtask

  task automatic test_same_requester();
    logic [11:0] tv [9];
    logic [3:0]  g;
    tv = '{ {1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1},
            {1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1},
            {1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1},
            {1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1},
            {1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1},
            {1'b1, 4'b0010, 4'b0000, 2'd0, 1'b1},
            {1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1},
            {1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1},
            {1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0} };
    for (int s = 0; s < 9; s++) begin
      RN = tv[s][11]; bus_a.REQ = tv[s][10:7];
      tick();
      g = tv[s][6:3];
      n_checks++;
      if ({bus_a.GNT, bus_a.EN, bus_a.EN_BAR, bus_a.BUSY} !== {g, g, ~g, tv[s][0]}) begin
        n_fail++;
        $display("FAIL same_req step %0d: gnt=%b en=%b en_bar=%b busy=%b, expected gnt=en=%b busy=%b",
                 s, bus_a.GNT, bus_a.EN, bus_a.EN_BAR, bus_a.BUSY, g, tv[s][0]);
      end
      if (g != 4'b0000) begin
        n_checks++;
        if (bus_a.OWNER !== tv[s][2:1]) begin
          n_fail++;
          $display("FAIL same_req owner step %0d: owner=%0d expected %0d", s, bus_a.OWNER, tv[s][2:1]);
        end
      end
    end
  endtask

  task automatic test_short_pulse();
    for (int s = 0; s < 2; s++) begin
      bus_a.REQ = (s == 0) ? 4'b0100 : 4'b1001;
      #3;
      bus_a.REQ = 4'b0000;
      tick();
      n_checks++;
      if ({bus_a.GNT, bus_a.EN, bus_a.EN_BAR, bus_a.BUSY} !== 13'b0000_0000_1111_0) begin
        n_fail++;
        $display("FAIL short_pulse %0d: gnt=%b en=%b en_bar=%b busy=%b, expected 0000 0000 1111 0",
                 s, bus_a.GNT, bus_a.EN, bus_a.EN_BAR, bus_a.BUSY);
      end
    end
  endtask

  task automatic test_dead3();
    logic [11:0] tv [9];
    logic [3:0]  g;
    tv = '{ {1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1},
            {1'b1, 4'b0001, 4'b0000, 2'd0, 1'b1},
            {1'b1, 4'b0001, 4'b0000, 2'd0, 1'b1},
            {1'b1, 4'b0001, 4'b0000, 2'd0, 1'b1},
            {1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1},
            {1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1},
            {1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1},
            {1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1},
            {1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0} };
    for (int s = 0; s < 9; s++) begin
      RN = tv[s][11]; bus_b.REQ = tv[s][10:7];
      tick();
      g = tv[s][6:3];
      n_checks++;
      if ({bus_b.GNT, bus_b.EN, bus_b.EN_BAR, bus_b.BUSY} !== {g, g, ~g, tv[s][0]}) begin
        n_fail++;
        $display("FAIL dead3 step %0d: gnt=%b en=%b en_bar=%b busy=%b, expected gnt=en=%b busy=%b",
                 s, bus_b.GNT, bus_b.EN, bus_b.EN_BAR, bus_b.BUSY, g, tv[s][0]);
      end
      if (g != 4'b0000) begin
        n_checks++;
        if (bus_b.OWNER !== tv[s][2:1]) begin
          n_fail++;
          $display("FAIL dead3 owner step %0d: owner=%0d expected %0d", s, bus_b.OWNER, tv[s][2:1]);
        end
      end
    end
  endtask

  task automatic test_hold_limit();
    logic [3:0] exp_en;
    int         n_cyc;
`ifdef GF180MCU_OSU_SC_TBUF_ARB_HOLD_LIMIT_EN
    n_cyc = 15;
`else
    n_cyc = 120;
`endif
    bus_h.REQ = 4'b0001;
    for (int k = 1; k <= n_cyc; k++) begin
      tick();
`ifdef GF180MCU_OSU_SC_TBUF_ARB_HOLD_LIMIT_EN
      exp_en = ((k % 5) != 0) ? 4'b0001 : 4'b0000;
`else
      exp_en = 4'b0001;
`endif
      n_checks++;
      if ({bus_h.EN, bus_h.EN_BAR, bus_h.BUSY} !== {exp_en, ~exp_en, 1'b1}) begin
        n_fail++;
        $display("FAIL hold cycle %0d: en=%b en_bar=%b busy=%b, expected en=%b busy=1",
                 k, bus_h.EN, bus_h.EN_BAR, bus_h.BUSY, exp_en);
      end
    end
    bus_h.REQ = 4'b0000;
    tick(); tick();
    n_checks++;
    if ({bus_h.EN, bus_h.BUSY} !== 5'b0000_0) begin
      n_fail++;
      $display("FAIL hold release: en=%b busy=%b, expected 0000 0", bus_h.EN, bus_h.BUSY);
    end
  endtask

  task automatic test_reset_mid_drive();
    logic [11:0] tv [8];
    logic [3:0]  g;
    tv = '{ {1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1},
            {1'b1, 4'b1111, 4'b0100, 2'd2, 1'b1},
            {1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0},
            {1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0},
            {1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0},
            {1'b1, 4'b1111, 4'b0001, 2'd0, 1'b1},
            {1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1},
            {1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0} };
    for (int s = 0; s < 8; s++) begin
      RN = tv[s][11]; bus_a.REQ = tv[s][10:7];
      tick();
      g = tv[s][6:3];
      n_checks++;
      if ({bus_a.GNT, bus_a.EN, bus_a.EN_BAR, bus_a.BUSY} !== {g, g, ~g, tv[s][0]}) begin
        n_fail++;
        $display("FAIL reset_mid step %0d: gnt=%b en=%b en_bar=%b busy=%b, expected gnt=en=%b busy=%b",
                 s, bus_a.GNT, bus_a.EN, bus_a.EN_BAR, bus_a.BUSY, g, tv[s][0]);
      end
      if (g != 4'b0000 || !tv[s][11]) begin
        n_checks++;
        if (bus_a.OWNER !== tv[s][2:1]) begin
          n_fail++;
          $display("FAIL reset_mid owner step %0d: owner=%0d expected %0d", s, bus_a.OWNER, tv[s][2:1]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r, en, prev_en;
    int         hold [4];
    int         waits [4];
    int         wcyc [4];
    int         zero_run;
    bit         seen;
    r = '0; prev_en = '0; zero_run = 0; seen = 1'b0;
    for (int i = 0; i < 4; i++) begin hold[i] = 0; waits[i] = 0; wcyc[i] = 0; end
    bus_a.REQ = r;
    for (int c = 0; c < 10000; c++) begin
      tick();
      en = bus_a.EN;
      n_checks++;
      if (!$onehot0(en) || bus_a.GNT !== en || bus_a.EN_BAR !== ~en) begin
        n_fail++;
        $display("FAIL rand_onehot cyc %0d: gnt=%b en=%b en_bar=%b", c, bus_a.GNT, en, bus_a.EN_BAR);
      end
      if (en != 4'b0000 && prev_en != 4'b0000) begin
        n_checks++;
        if (en !== prev_en) begin
          n_fail++;
          $display("FAIL rand_no_gap cyc %0d: en=%b prev=%b, expected no owner change without gap", c, en, prev_en);
        end
      end
      if (en != 4'b0000 && prev_en == 4'b0000) begin
        if (seen) begin
          n_checks++;
          if (zero_run < A_DEAD) begin
            n_fail++;
            $display("FAIL rand_gap cyc %0d: gap=%0d expected >= %0d", c, zero_run, A_DEAD);
          end
        end
        seen = 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (en[i]) waits[i] = 0;
          else if (r[i]) begin
            waits[i]++;
            n_checks++;
            if (waits[i] > 3) begin
              n_fail++;
              $display("FAIL rand_fair cyc %0d: req %0d waited %0d grants, expected <= 3", c, i, waits[i]);
            end
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (r[i] && !en[i]) begin
          wcyc[i]++;
          n_checks++;
          if (wcyc[i] > 30) begin
            n_fail++;
            $display("FAIL rand_wait cyc %0d: req %0d pending %0d cycles, expected <= 30", c, i, wcyc[i]);
          end
        end else wcyc[i] = 0;
      end
      zero_run = (en == 4'b0000) ? zero_run + 1 : 0;
      for (int i = 0; i < 4; i++) begin
        if (r[i] && en[i]) begin
          hold[i]--;
          if (hold[i] == 0) begin r[i] = 1'b0; waits[i] = 0; end
        end else if (!r[i] && $urandom_range(0, 3) == 0) begin
          r[i] = 1'b1;
          hold[i] = int'($urandom_range(1, 5));
        end
      end
      bus_a.REQ = r;
      prev_en = en;
    end
    bus_a.REQ = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_rr_basic();
    test_rotation();
    test_same_requester();
    test_short_pulse();
    test_dead3();
    test_hold_limit();
    test_reset_mid_drive();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
